uart_rx_deserializer: RTL



---
 rtl/uart_rx_deserializer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: 2-of-3 majority sampling per bit, optional parity,
// and registered one-cycle DATA_VALID / PAR_ERR / STP_ERR strobes at frame end.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            dbg_state
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q,      state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q,   edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q,   prescale_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic [2:0]            sample_q,     sample_d;
    logic                  bit_q,        bit_d;
    logic                  par_bad_q,    par_bad_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stp_err_q,    stp_err_d;

    logic [PRESCALE_W-1:0] half;
    logic                  sample_point;
    logic                  decide_point;
    logic                  bit_end;
    logic                  majority;

    // Timing within a bit is derived from the PRESCALE latched at start detection.
    assign half         = prescale_q >> 1;
    assign sample_point = (edge_cnt_q == half - ONE) || (edge_cnt_q == half) ||
                          (edge_cnt_q == half + ONE);
    assign decide_point = (edge_cnt_q == half + TWO);
    assign bit_end      = (edge_cnt_q == prescale_q - ONE);
    assign majority     = (sample_q[0] & sample_q[1]) | (sample_q[0] & sample_q[2]) |
                          (sample_q[1] & sample_q[2]);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        sample_d     = sample_q;
        bit_d        = bit_q;
        par_bad_d    = par_bad_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q == S_IDLE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            // The detecting cycle is edge 0 of the start bit, so the count resumes at 1.
            if (!RX_IN) begin
                state_d    = S_START;
                edge_cnt_d = ONE;
                prescale_d = PRESCALE;
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_bad_d  = 1'b0;
            end
        end else begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + ONE;
            if (bit_end) begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
            if (sample_point) begin
                sample_d = {sample_q[1:0], RX_IN};
            end
            if (decide_point) begin
                bit_d = majority;
            end

            case (state_q)
                S_START: begin
                    if (decide_point && majority) begin
                        state_d    = S_IDLE;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else if (bit_end) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide_point) begin
                        shift_d = {majority, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (bit_end && (bit_cnt_q == LAST_DATA_BIT)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (decide_point) begin
                        par_bad_d = majority ^ (^shift_q) ^ par_typ_q;
                    end
                    if (bit_end) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    // Returning to IDLE lets a start bit on the very next cycle be caught.
                    if (bit_end) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        stp_err_d = ~bit_q;
                        par_err_d = par_en_q & par_bad_q;
                        if (bit_q && !(par_en_q && par_bad_q)) begin
                            p_data_d     = shift_q;
                            data_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            sample_q     <= '0;
            bit_q        <= 1'b0;
            par_bad_q    <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            sample_q     <= sample_d;
            bit_q        <= bit_d;
            par_bad_q    <= par_bad_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign dbg_state  = state_q;

endmodule
